// File: rtl/leb128_pkg.sv
// rtl/leb128_pkg.sv - shared state enum, length width and MAXB helper for the LEB128 decoder
package leb128_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int LEN_W = 4;

   function automatic int maxb(input int w);
      return (w + 6) / 7;
   endfunction

endpackage

// File: rtl/leb128_stream_decoder_if.sv
// rtl/leb128_stream_decoder_if.sv - encoded-byte input stream and decoded-value output stream
interface leb128_stream_decoder_if #(
   parameter int W = 32
) ();
   import leb128_pkg::*;

   logic             signed_mode;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     out_data;
   logic [LEN_W-1:0] out_len;
   logic             out_err;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  signed_mode, in_data, in_valid, out_ready,
      output in_ready, out_data, out_len, out_err, out_valid
   );

   modport master (
      output signed_mode, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_len, out_err, out_valid
   );

endinterface

// File: rtl/leb128_sext.sv
// rtl/leb128_sext.sv - fills bits above 7*cnt with ones for a negative signed LEB128 value
module leb128_sext
   import leb128_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0]     acc_i,
   input  logic [LEN_W-1:0] cnt_i,
   input  logic             sign_i,
   input  logic             signed_i,
   output logic [W-1:0]     val_o
);

   logic [7:0] nbits;

   assign nbits = 8'(cnt_i) * 8'd7;

   always_comb begin
      val_o = acc_i;
      if (signed_i && sign_i && (int'(nbits) < W)) begin
         val_o = acc_i | ({W{1'b1}} << nbits);
      end
   end

endmodule

// File: rtl/leb128_stream_decoder.sv
// rtl/leb128_stream_decoder.sv - byte-serial LEB128 decoder, one value out per terminator byte
// Optional strict unused-bit check on the final byte: LEB128_DEC_STRICT_EN
module leb128_stream_decoder
   import leb128_pkg::*;
#(
   parameter int W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   leb128_stream_decoder_if.slave   bus_io
);

   localparam int               MAXB   = maxb(W);
   localparam logic [LEN_W-1:0] MAXB_L = LEN_W'(MAXB);
   // Payload bits of the MAXB-th byte that still land inside W.
   localparam int               USED   = W - 7 * (MAXB - 1);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d, cnt_new;
   logic [W-1:0]     acc_q, acc_d, acc_new, sext_val, payload_w;
   logic             signed_q, signed_d, signed_eff;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [LEN_W-1:0] out_len_q, out_len_d;
   logic             out_err_q, out_err_d;
   logic             in_ready, accept, cont, strict_bad;
   logic [7:0]       shamt;

   assign in_ready   = !out_valid_q || bus_io.out_ready;
   assign accept     = bus_io.in_valid && in_ready;
   assign cont       = bus_io.in_data[7];
   assign signed_eff = (state_q == ST_IDLE) ? bus_io.signed_mode : signed_q;
   assign cnt_new    = cnt_q + LEN_W'(1);
   assign shamt      = 8'(cnt_q) * 8'd7;
   assign payload_w  = {{(W-7){1'b0}}, bus_io.in_data[6:0]};
   assign acc_new    = acc_q | (payload_w << shamt);

`ifdef LEB128_DEC_STRICT_EN
   localparam logic [6:0] UNUSED_MASK = 7'(7'h7F << USED);
   logic [6:0] fill;

   assign fill       = (signed_eff && bus_io.in_data[USED-1]) ? UNUSED_MASK : 7'h00;
   assign strict_bad = (cnt_new == MAXB_L) && ((bus_io.in_data[6:0] & UNUSED_MASK) != fill);
`else
   assign strict_bad = 1'b0;
`endif

   leb128_sext #(.W(W)) u_sext (
      .acc_i    (acc_new),
      .cnt_i    (cnt_new),
      .sign_i   (bus_io.in_data[6]),
      .signed_i (signed_eff),
      .val_o    (sext_val)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         signed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_len_q   <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         signed_q    <= signed_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_len_q   <= out_len_d;
         out_err_q   <= out_err_d;
      end
   end

   // cnt/acc are cleared on every terminator so IDLE always starts from zero.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      signed_d    = signed_q;
      out_valid_d = out_valid_q && !bus_io.out_ready;
      out_data_d  = out_data_q;
      out_len_d   = out_len_q;
      out_err_d   = out_err_q;
      if (accept) begin
         case (state_q)
            ST_IDLE, ST_ACC: begin
               signed_d = signed_eff;
               if (cont) begin
                  cnt_d = cnt_new;
                  if (cnt_new == MAXB_L) begin
                     state_d = ST_DRAIN;
                     acc_d   = '0;
                  end else begin
                     state_d = ST_ACC;
                     acc_d   = acc_new;
                  end
               end else begin
                  state_d     = ST_IDLE;
                  cnt_d       = '0;
                  acc_d       = '0;
                  out_valid_d = 1'b1;
                  if (strict_bad) begin
                     out_err_d  = 1'b1;
                     out_data_d = '0;
                     out_len_d  = MAXB_L;
                  end else begin
                     out_err_d  = 1'b0;
                     out_data_d = sext_val;
                     out_len_d  = cnt_new;
                  end
               end
            end
            ST_DRAIN: begin
               if (!cont) begin
                  state_d     = ST_IDLE;
                  cnt_d       = '0;
                  out_valid_d = 1'b1;
                  out_err_d   = 1'b1;
                  out_data_d  = '0;
                  out_len_d   = MAXB_L;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_data  = out_data_q;
   assign bus_io.out_len   = out_len_q;
   assign bus_io.out_err   = out_err_q;

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// tb/tb_leb128_stream_decoder.sv - directed vector bench for W=32 and W=64 decoder instances
module tb_leb128_stream_decoder;

   typedef struct {
      logic        sgn;
      int          n;
      logic [79:0] bytes;
      logic [31:0] data;
      logic [3:0]  len;
      logic        err;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   leb128_stream_decoder_if #(.W(32)) i32 ();
   leb128_stream_decoder_if #(.W(64)) i64 ();

   leb128_stream_decoder #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus_io(i32.slave));
   leb128_stream_decoder #(.W(64)) dut64 (.clk(clk), .rst(rst), .bus_io(i64.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic sgn, input int n, input logic [79:0] bytes,
                               input logic [31:0] data, input logic [3:0] len, input logic err);
      vec_t v;
      v.sgn = sgn; v.n = n; v.bytes = bytes; v.data = data; v.len = len; v.err = err;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Bytes are packed first-byte-lowest; sampling happens 1 time unit after each edge.
   task automatic send32(input logic sgn, input logic [79:0] bytes, input int n,
                         output logic spurious);
      spurious = 1'b0;
      for (int i = 0; i < n; i++) begin
         i32.signed_mode = sgn;
         i32.in_data     = bytes[8*i +: 8];
         i32.in_valid    = 1'b1;
         @(posedge clk); #1;
         if (i < n - 1 && i32.out_valid) spurious = 1'b1;
      end
      i32.in_valid = 1'b0;
   endtask

   task automatic send64(input logic sgn, input logic [79:0] bytes, input int n);
      for (int i = 0; i < n; i++) begin
         i64.signed_mode = sgn;
         i64.in_data     = bytes[8*i +: 8];
         i64.in_valid    = 1'b1;
         @(posedge clk); #1;
      end
      i64.in_valid = 1'b0;
   endtask

   vec_t vecs [13];
   logic spur;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      i32.signed_mode = 1'b0; i32.in_data = 8'h00; i32.in_valid = 1'b0; i32.out_ready = 1'b1;
      i64.signed_mode = 1'b0; i64.in_data = 8'h00; i64.in_valid = 1'b0; i64.out_ready = 1'b1;

      vecs[0]  = mk(1'b0, 3, 80'h26_8E_E5,          32'h0009_8765, 4'd3, 1'b0);
      vecs[1]  = mk(1'b1, 3, 80'h78_BB_C0,          32'hFFFE_1DC0, 4'd3, 1'b0);
      vecs[2]  = mk(1'b1, 1, 80'h7F,                32'hFFFF_FFFF, 4'd1, 1'b0);
      vecs[3]  = mk(1'b0, 1, 80'h7F,                32'h0000_007F, 4'd1, 1'b0);
      vecs[4]  = mk(1'b0, 6, 80'h01_FF_FF_FF_FF_FF, 32'h0,         4'd5, 1'b1);
`ifdef LEB128_DEC_STRICT_EN
      vecs[5]  = mk(1'b0, 5, 80'h1F_FF_FF_FF_FF,    32'h0,         4'd5, 1'b1);
      vecs[6]  = mk(1'b1, 5, 80'h0F_FF_FF_FF_FF,    32'h0,         4'd5, 1'b1);
`else
      vecs[5]  = mk(1'b0, 5, 80'h1F_FF_FF_FF_FF,    32'hFFFF_FFFF, 4'd5, 1'b0);
      vecs[6]  = mk(1'b1, 5, 80'h0F_FF_FF_FF_FF,    32'hFFFF_FFFF, 4'd5, 1'b0);
`endif
      vecs[7]  = mk(1'b0, 1, 80'h00,                32'h0,         4'd1, 1'b0);
      vecs[8]  = mk(1'b0, 2, 80'h00_80,             32'h0,         4'd2, 1'b0);
      vecs[9]  = mk(1'b1, 5, 80'h7F_80_80_80_80,    32'hF000_0000, 4'd5, 1'b0);
      vecs[10] = mk(1'b0, 2, 80'h01_8F,             32'h0000_008F, 4'd2, 1'b0);
      vecs[11] = mk(1'b1, 1, 80'h40,                32'hFFFF_FFC0, 4'd1, 1'b0);
      vecs[12] = mk(1'b0, 8, 80'h00_FF_FF_FF_FF_FF_FF_FF, 32'h0,   4'd5, 1'b1);

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(i32.out_valid), 64'd0);
      check("rst_out_data",  64'(i32.out_data),  64'd0);
      check("rst_out_len",   64'(i32.out_len),   64'd0);
      check("rst_out_err",   64'(i32.out_err),   64'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready",  64'(i32.in_ready),  64'd1);
      @(posedge clk); #1;

      for (int k = 0; k < 13; k++) begin
         send32(vecs[k].sgn, vecs[k].bytes, vecs[k].n, spur);
         check($sformatf("v%0d_early", k), 64'(spur),           64'd0);
         check($sformatf("v%0d_valid", k), 64'(i32.out_valid),  64'd1);
         check($sformatf("v%0d_data",  k), 64'(i32.out_data),   64'(vecs[k].data));
         check($sformatf("v%0d_len",   k), 64'(i32.out_len),    64'(vecs[k].len));
         check($sformatf("v%0d_err",   k), 64'(i32.out_err),    64'(vecs[k].err));
         @(posedge clk); #1;
         check($sformatf("v%0d_single", k), 64'(i32.out_valid), 64'd0);
      end

      // Back-to-back values: result handshake and next terminator in the same cycle.
      send32(1'b0, 80'h26_8E_E5, 3, spur);
      check("b2b_first_data", 64'(i32.out_data), 64'h0009_8765);
      send32(1'b0, 80'h7F, 1, spur);
      check("b2b_valid_held", 64'(i32.out_valid), 64'd1);
      check("b2b_second_data", 64'(i32.out_data), 64'h7F);
      check("b2b_second_len", 64'(i32.out_len), 64'd1);
      @(posedge clk); #1;
      check("b2b_drained", 64'(i32.out_valid), 64'd0);

      // Backpressure: pending 05 blocks the 06 byte until out_ready returns.
      i32.out_ready = 1'b0;
      send32(1'b0, 80'h05, 1, spur);
      check("bp_pending_data", 64'(i32.out_data), 64'h05);
      i32.in_data = 8'h06; i32.in_valid = 1'b1;
      #1;
      check("bp_in_ready_low", 64'(i32.in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(i32.out_valid), 64'd1);
      check("bp_hold_data",  64'(i32.out_data),  64'h05);
      i32.out_ready = 1'b1;
      #1;
      check("bp_in_ready_high", 64'(i32.in_ready), 64'd1);
      @(posedge clk); #1;
      i32.in_valid = 1'b0;
      check("bp_next_data", 64'(i32.out_data), 64'h06);
      check("bp_next_valid", 64'(i32.out_valid), 64'd1);
      @(posedge clk); #1;
      check("bp_done", 64'(i32.out_valid), 64'd0);

      // Reset mid-value, then mid-drain: partial values must vanish.
      send32(1'b0, 80'h80_80, 2, spur);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstmid_no_out", 64'(i32.out_valid), 64'd0);
      rst = 1'b0;
      send32(1'b0, 80'h05, 1, spur);
      check("rstmid_data", 64'(i32.out_data), 64'h05);
      check("rstmid_len",  64'(i32.out_len),  64'd1);
      @(posedge clk); #1;
      send32(1'b0, 80'hFF_FF_FF_FF_FF_FF, 6, spur);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send32(1'b0, 80'h05, 1, spur);
      check("rstdrain_data", 64'(i32.out_data), 64'h05);
      check("rstdrain_err",  64'(i32.out_err),  64'd0);
      check("rstdrain_len",  64'(i32.out_len),  64'd1);
      @(posedge clk); #1;

      // W=64 instance: ten-byte maximum and overlong.
      send64(1'b1, 80'h7F_80_80_80_80_80_80_80_80_80, 10);
      check("w64_valid", 64'(i64.out_valid), 64'd1);
      check("w64_data",  i64.out_data,       64'h8000_0000_0000_0000);
      check("w64_len",   64'(i64.out_len),   64'd10);
      check("w64_err",   64'(i64.out_err),   64'd0);
      @(posedge clk); #1;
      send64(1'b0, 80'hFF_FF_FF_FF_FF_FF_FF_FF_FF_FF, 10);
      check("w64_ovl_pending", 64'(i64.out_valid), 64'd0);
      send64(1'b0, 80'h01, 1);
      check("w64_ovl_err",  64'(i64.out_err),  64'd1);
      check("w64_ovl_data", i64.out_data,      64'd0);
      check("w64_ovl_len",  64'(i64.out_len),  64'd10);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/leb128_stream_decoder.md
# leb128_stream_decoder

Byte-serial LEB128 decoder that generalises the combinational 5-byte i32/u32 unpackers to a parameterised width. It accepts one encoded byte per cycle over a valid/ready stream and emits one decoded integer per value over a second valid/ready stream. Signed or unsigned decoding is selected per value, and overlong encodings are flagged. It sits between the byte-oriented section parser and the operand/immediate consumers.

## Interface
- W, 32: decoded width; legal values 32 and 64.
- MAXB, (W+6)/7: maximum legal encoded length in bytes (5 for W=32, 10 for W=64); derived, never overridden.
- clk  in  1  system clock; one clock, all logic on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- signed_mode  in  1  1 = signed LEB128, 0 = unsigned; sampled with the first byte of each value.
- in_data  in  8  encoded byte; bit 7 = continuation, bits 6:0 = payload.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_data  out  W  decoded value; 0 when out_err.
- out_len  out  4  bytes consumed; saturates at MAXB.
- out_err  out  1  encoding error (overlong, or strict-check failure).
- out_valid  out  1  result valid.
- out_ready  in  1  result taken when out_valid && out_ready.

## Operation
- States:
  - IDLE: no partial value.
  - ACC: collecting bytes.
  - DRAIN: overlong; discarding bytes until a terminator.
- Accepting a byte with counter cnt:
  - acc |= payload << 7*cnt, truncated to W.
  - cnt++.
  - In IDLE, signed_mode is latched.
- Terminator (bit7=0) in IDLE/ACC:
  - Result = acc.
  - If signed and payload bit 6 = 1 and 7*cnt_new < W: bits W-1..7*cnt_new are set to 1.
  - Result registers load; state returns to IDLE.
- Continuation byte when cnt_new == MAXB: go to DRAIN; cnt holds at MAXB.
- DRAIN on a terminator: emit out_err=1, out_data=0, out_len=MAXB; state to IDLE.
- Non-error result: out_err=0, out_len=cnt_new.
- in_ready = !out_valid || out_ready. This is the only backpressure path; bytes are accepted in every state.
- Reset values:
  - out_valid=0, out_data=0, out_len=0, out_err=0.
  - State IDLE, cnt=0, acc=0.
  - in_ready=1 once rst is low.

## Timing
- Latency: out_valid rises the cycle after the terminator byte is accepted.
- Throughput: 1 byte/cycle sustained, including back-to-back values when out_ready=1.
- A result handshake and a terminator accept in the same cycle: the new result replaces the old one, and out_valid stays 1.
- out_valid=1 with out_ready=0:
  - out_* hold stable.
  - in_ready=0, so no byte is accepted, including mid-value.
- rst asserted mid-value or mid-DRAIN: the partial value is discarded with no output; the next byte starts a fresh value.

## Configuration
- LEB128_DEC_STRICT_EN defined: on the MAXB-th byte, unused payload bits (above bit W-1-7*(MAXB-1)) are checked.
  - Unsigned: the unused bits must be 0.
  - Signed: the unused bits must equal the top used bit.
  - On violation: out_err=1, out_data=0, out_len=MAXB.
- Undefined: unused bits are silently truncated; only overlong length is an error.

## Structure
- Package leb128_pkg:
  - State enum (IDLE/ACC/DRAIN).
  - Function maxb(W).
  - Localparam for out_len width (4).
- Sub-module leb128_sext: combinational, inputs acc, cnt, sign bit, signed flag; outputs the sign-extended W-bit value. It is also reusable by an encoder.

## Test plan
- W=32, unsigned, bytes E5 8E 26, out_ready=1 -> out_data=0x00098765, out_len=3, out_err=0, out_valid one cycle after the 0x26 accept.
- W=32, signed, C0 BB 78 -> 0xFFFE1DC0 (-123456), len 3; signed 7F -> 0xFFFFFFFF, len 1; unsigned 7F -> 0x0000007F.
- W=32, FF FF FF FF FF 01 -> out_err=1, out_data=0, out_len=5, one output only.
- W=32, unsigned, FF FF FF FF 1F:
  - STRICT defined -> out_err=1.
  - Undefined -> 0xFFFFFFFF, len 5, err 0.
- W=64, signed, 80 ×9 then 7F -> 0x8000000000000000, len 10.
- Hold out_ready=0 with result 05 pending, offer 06 -> in_ready=0, 06 not taken. Release -> 05 handshakes, then 06 decoded. Assert rst after bytes 80 80, then send 05 -> single output 5, len 1.
